instruction_prefetch_unit: RTL

- Sequential fetch stage that reads the NoC node's 1024x32 single-port instruction memory through its Avalon-style slave port.
- Buffers fetched words in a small FIFO and presents them to the downstream core decode stage on a valid/ready stream, with each word tagged by its word address.
- Supports start, redirect (flush) and stop.
- Sits between the instruction memory and the core's decode stage in each 2x2 adaptor node.

---
 rtl/instruction_prefetch_unit.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/instruction_prefetch_unit.sv
// Sequential instruction fetch stage: reads the 1024x32 instruction memory and
// streams tagged words to decode through a small prefetch FIFO.
module instruction_prefetch_unit #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned RESET_PC   = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_addr,
    input  logic              stop,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_clken,
    output logic              mem_write,
    output logic [3:0]        mem_byteenable,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready,
    output logic              busy
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {S_IDLE, S_RUN} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic                inflight_q, inflight_d;
    logic [ADDR_W-1:0]   inflight_pc_q, inflight_pc_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [DATA_W-1:0]   data_q [FIFO_DEPTH];
    logic [DATA_W-1:0]   data_d [FIFO_DEPTH];
    logic [ADDR_W-1:0]   tag_q  [FIFO_DEPTH];
    logic [ADDR_W-1:0]   tag_d  [FIFO_DEPTH];

    logic redirect_c;
    logic issue_c;
    logic push_c;
    logic pop_c;

    // Any control pulse discards buffered and in-flight words and blocks issue.
    assign redirect_c = stop | flush | start;
    assign issue_c    = (state_q == S_RUN) && !redirect_c &&
                        ((CNT_W+1)'(count_q) + (CNT_W+1)'(inflight_q) < (CNT_W+1)'(FIFO_DEPTH));
    assign push_c     = inflight_q & ~redirect_c;
    assign pop_c      = instr_valid & instr_ready & ~redirect_c;

    assign mem_address    = issue_c ? pc_q : '0;
    assign mem_chipselect = issue_c;
    assign mem_clken      = issue_c;
    assign mem_write      = 1'b0;
    assign mem_byteenable = 4'hF;

    assign instr_valid = (count_q != '0);
    assign instr_data  = data_q[rd_ptr_q];
    assign instr_pc    = tag_q[rd_ptr_q];
    assign busy        = (state_q == S_RUN);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_d    = issue_c;
        inflight_pc_d = inflight_pc_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        data_d        = data_q;
        tag_d         = tag_q;

        if (issue_c) begin
            inflight_pc_d = pc_q;
            pc_d          = pc_q + ADDR_W'(1);
        end

        if (push_c) begin
            data_d[wr_ptr_q] = mem_readdata;
            tag_d[wr_ptr_q]  = inflight_pc_q;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (redirect_c) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end

        // stop outranks flush, which outranks start
        if (stop) begin
            state_d = S_IDLE;
        end else if (flush) begin
            state_d = S_RUN;
            pc_d    = flush_addr;
        end else if (start) begin
            state_d = S_RUN;
            pc_d    = start_addr;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            pc_q          <= ADDR_W'(RESET_PC);
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            data_q        <= data_d;
            tag_q         <= tag_d;
        end
    end

endmodule
